// File: rtl/reg_file_pkg.sv
// Types, default widths and the write-priority helper shared by the
// register file storage path and its read-port bypass.
package reg_file_pkg;

   typedef enum logic {
      IDLE     = 1'b0,
      CLEARING = 1'b1
   } state_t;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_ADDR_W = 4;
   localparam int DEF_NUM_RD = 2;
   localparam int DEF_NUM_WR = 2;

   // Upper bound on write ports; match vectors are carried at this width.
   localparam int MAX_WR = 8;

   // Keeps only the highest-index set bit, i.e. the winning write port.
   function automatic logic [MAX_WR-1:0] win_mask(input logic [MAX_WR-1:0] match);
      logic [MAX_WR-1:0] mask;
      logic              found;
      mask  = '0;
      found = 1'b0;
      for (int i = MAX_WR - 1; i >= 0; i--) begin
         if (match[i] && !found) begin
            mask[i] = 1'b1;
            found   = 1'b1;
         end
      end
      return mask;
   endfunction

endpackage

// File: rtl/reg_file_wr_arb.sv
// One read port: picks the zero register, the same-cycle winning write
// (bypass) or the stored entry.
module reg_file_wr_arb
   import reg_file_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int NUM_WR   = DEF_NUM_WR,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 0
) (
   input  logic                           bypass_en,
   input  logic [ADDR_W-1:0]              rd_addr,
   input  logic [DATA_W-1:0]              stored_data,
   input  logic                           stored_busy,
   input  logic [NUM_WR-1:0]              wr_en,
   input  logic [NUM_WR-1:0][ADDR_W-1:0]  wr_addr,
   input  logic [NUM_WR-1:0][DATA_W-1:0]  wr_data,
   output logic [DATA_W-1:0]              rd_data,
   output logic                           rd_busy
);

   logic [MAX_WR-1:0] match;
   logic [MAX_WR-1:0] mask;
   logic [DATA_W-1:0] byp_data;
   logic              hit;

   always_comb begin
      match = '0;
      for (int i = 0; i < NUM_WR; i++) begin
         match[i] = wr_en[i] && (wr_addr[i] == rd_addr);
      end
      mask = win_mask(match);
      hit  = (BYPASS != 0) && bypass_en && (|mask);

      byp_data = '0;
      for (int i = 0; i < NUM_WR; i++) begin
         if (mask[i]) byp_data = wr_data[i];
      end

      // A bypassed write clears busy at the edge, so report it as not busy now.
      if ((ZERO_REG != 0) && (rd_addr == '0)) begin
         rd_data = '0;
         rd_busy = 1'b0;
      end else if (hit) begin
         rd_data = byp_data;
         rd_busy = 1'b0;
      end else begin
         rd_data = stored_data;
         rd_busy = stored_busy;
      end
   end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with pending-write scoreboard and a
// one-entry-per-cycle clear engine.
module reg_file_mp
   import reg_file_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int NUM_RD   = DEF_NUM_RD,
   parameter int NUM_WR   = DEF_NUM_WR,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 0
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic [NUM_RD-1:0][ADDR_W-1:0]  rd_addr,
   output logic [NUM_RD-1:0][DATA_W-1:0]  rd_data,
   output logic [NUM_RD-1:0]              rd_busy,
   input  logic [NUM_WR-1:0]              wr_en,
   input  logic [NUM_WR-1:0][ADDR_W-1:0]  wr_addr,
   input  logic [NUM_WR-1:0][DATA_W-1:0]  wr_data,
   input  logic                           rsv_en,
   input  logic [ADDR_W-1:0]              rsv_addr,
   input  logic                           clear,
   output logic                           ready,
   output state_t                         fsm_state
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

   logic [DEPTH-1:0][DATA_W-1:0] mem;
   logic [DEPTH-1:0]             busy;
   state_t                       state;
   logic [ADDR_W-1:0]            ptr;

   logic [DEPTH-1:0][MAX_WR-1:0] wr_match;
   logic [DEPTH-1:0][MAX_WR-1:0] wr_mask;
   logic [DEPTH-1:0]             wr_hit;
   logic [DEPTH-1:0][DATA_W-1:0] wr_val;
   logic [DEPTH-1:0]             rsv_hit;

   assign fsm_state = state;

   // Per-entry write decode; entry 0 ignores writes and reservations when hardwired.
   always_comb begin
      for (int e = 0; e < DEPTH; e++) begin
         wr_match[e] = '0;
         for (int i = 0; i < NUM_WR; i++) begin
            wr_match[e][i] = wr_en[i] && (wr_addr[i] == ADDR_W'(e));
         end
         wr_mask[e] = win_mask(wr_match[e]);
         wr_hit[e]  = |wr_mask[e];
         wr_val[e]  = '0;
         for (int i = 0; i < NUM_WR; i++) begin
            if (wr_mask[e][i]) wr_val[e] = wr_data[i];
         end
         rsv_hit[e] = rsv_en && (rsv_addr == ADDR_W'(e));
         if ((ZERO_REG != 0) && (e == 0)) begin
            wr_hit[e]  = 1'b0;
            rsv_hit[e] = 1'b0;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         mem   <= '0;
         busy  <= '0;
         state <= IDLE;
         ptr   <= '0;
         ready <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               // Reservation is applied after the write so it wins on busy.
               for (int e = 0; e < DEPTH; e++) begin
                  if (wr_hit[e]) begin
                     mem[e]  <= wr_val[e];
                     busy[e] <= 1'b0;
                  end
                  if (rsv_hit[e]) busy[e] <= 1'b1;
               end
               if (clear) begin
                  state <= CLEARING;
                  ptr   <= '0;
                  ready <= 1'b0;
               end
            end
            CLEARING: begin
               mem[ptr]  <= '0;
               busy[ptr] <= 1'b0;
               if (ptr == LAST) begin
                  state <= IDLE;
                  ready <= 1'b1;
               end else begin
                  ptr <= ptr + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               ready <= 1'b1;
            end
         endcase
      end
   end

   for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
      reg_file_wr_arb #(
         .DATA_W   (DATA_W),
         .ADDR_W   (ADDR_W),
         .NUM_WR   (NUM_WR),
         .BYPASS   (BYPASS),
         .ZERO_REG (ZERO_REG)
      ) u_arb (
         .bypass_en   (state == IDLE),
         .rd_addr     (rd_addr[r]),
         .stored_data (mem[rd_addr[r]]),
         .stored_busy (busy[rd_addr[r]]),
         .wr_en       (wr_en),
         .wr_addr     (wr_addr),
         .wr_data     (wr_data),
         .rd_data     (rd_data[r]),
         .rd_busy     (rd_busy[r])
      );
   end

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: directed scenarios plus random traffic, with a
// normal and a hardwired-zero instance driven by the same inputs.
module tb_reg_file_mp;

   localparam int DW    = 8;
   localparam int AW    = 4;
   localparam int NR    = 2;
   localparam int NW    = 2;
   localparam int DEPTH = 16;

   logic                   clock = 1'b0;
   logic                   reset;
   logic [NR-1:0][AW-1:0]  rd_addr;
   logic [NR-1:0][DW-1:0]  rd_data, rd_data_z;
   logic [NR-1:0]          rd_busy, rd_busy_z;
   logic [NW-1:0]          wr_en;
   logic [NW-1:0][AW-1:0]  wr_addr;
   logic [NW-1:0][DW-1:0]  wr_data;
   logic                   rsv_en;
   logic [AW-1:0]          rsv_addr;
   logic                   clear;
   logic                   ready, ready_z;
   reg_file_pkg::state_t   fsm_state, fsm_state_z;

   // Reference model: index 0 = normal instance, 1 = zero-register instance.
   logic [DW-1:0] m_mem  [2][DEPTH];
   bit            m_busy [2][DEPTH];
   bit            m_clr;
   int            m_ptr;
   logic [DW-1:0] exp_q[$];

   int n_cmp = 0;
   int n_err = 0;

   always #5 clock = ~clock;

   reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW),
                 .BYPASS(1), .ZERO_REG(0)) u_dut (
      .clock(clock), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
      .rd_busy(rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rsv_en(rsv_en), .rsv_addr(rsv_addr), .clear(clear), .ready(ready),
      .fsm_state(fsm_state)
   );

   reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW),
                 .BYPASS(1), .ZERO_REG(1)) u_dut_z (
      .clock(clock), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_z),
      .rd_busy(rd_busy_z), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rsv_en(rsv_en), .rsv_addr(rsv_addr), .clear(clear), .ready(ready_z),
      .fsm_state(fsm_state_z)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] exp_data(input int z, input logic [AW-1:0] a);
      logic [DW-1:0] v;
      v = m_mem[z][a];
      if (z == 1 && a == 0) return '0;
      if (!m_clr) begin
         for (int i = 0; i < NW; i++) if (wr_en[i] && wr_addr[i] == a) v = wr_data[i];
      end
      return v;
   endfunction

   function automatic bit exp_busy(input int z, input logic [AW-1:0] a);
      bit b;
      b = m_busy[z][a];
      if (z == 1 && a == 0) return 1'b0;
      if (!m_clr) begin
         for (int i = 0; i < NW; i++) if (wr_en[i] && wr_addr[i] == a) b = 1'b0;
      end
      return b;
   endfunction

   task automatic check_outputs();
      for (int r = 0; r < NR; r++) begin
         exp_q.push_back(exp_data(0, rd_addr[r]));
         exp_q.push_back(exp_data(1, rd_addr[r]));
      end
      for (int r = 0; r < NR; r++) begin
         check_val("rd_data", rd_data[r], exp_q.pop_front());
         check_val("rd_data_z", rd_data_z[r], exp_q.pop_front());
         check_val("rd_busy", rd_busy[r], exp_busy(0, rd_addr[r]));
         check_val("rd_busy_z", rd_busy_z[r], exp_busy(1, rd_addr[r]));
      end
      check_val("ready", ready, !m_clr);
      check_val("ready_z", ready_z, !m_clr);
      check_val("state", 32'(fsm_state), m_clr ? 32'd1 : 32'd0);
   endtask

   // Applies the effect of one rising edge using the inputs currently driven.
   task automatic model_edge();
      if (reset) begin
         for (int z = 0; z < 2; z++)
            for (int e = 0; e < DEPTH; e++) begin
               m_mem[z][e]  = '0;
               m_busy[z][e] = 1'b0;
            end
         m_clr = 1'b0;
      end else if (!m_clr) begin
         for (int z = 0; z < 2; z++) begin
            for (int i = 0; i < NW; i++) begin
               if (wr_en[i] && !(z == 1 && wr_addr[i] == 0)) begin
                  m_mem[z][wr_addr[i]]  = wr_data[i];
                  m_busy[z][wr_addr[i]] = 1'b0;
               end
            end
            if (rsv_en && !(z == 1 && rsv_addr == 0)) m_busy[z][rsv_addr] = 1'b1;
         end
         if (clear) begin
            m_clr = 1'b1;
            m_ptr = 0;
         end
      end else begin
         for (int z = 0; z < 2; z++) begin
            m_mem[z][m_ptr]  = '0;
            m_busy[z][m_ptr] = 1'b0;
         end
         m_ptr++;
         if (m_ptr == DEPTH) m_clr = 1'b0;
      end
   endtask

   task automatic cycle(input bit chk);
      #1;
      if (chk) check_outputs();
      @(posedge clock);
      model_edge();
      @(negedge clock);
   endtask

   task automatic idle_inputs();
      wr_en    = '0;
      wr_addr  = '0;
      wr_data  = '0;
      rsv_en   = 1'b0;
      rsv_addr = '0;
      clear    = 1'b0;
   endtask

   task automatic fill_all();
      for (int a = 0; a < DEPTH; a += 2) begin
         wr_en      = 2'b11;
         wr_addr[0] = AW'(a);
         wr_addr[1] = AW'(a + 1);
         wr_data[0] = DW'($urandom_range(1, 255));
         wr_data[1] = DW'($urandom_range(1, 255));
         rsv_en     = 1'b0;
         cycle(1);
      end
      idle_inputs();
      for (int a = 0; a < DEPTH; a += 3) begin
         rsv_en   = 1'b1;
         rsv_addr = AW'(a);
         cycle(1);
      end
      idle_inputs();
   endtask

   task automatic sweep_zero(input string tag);
      idle_inputs();
      for (int a = 0; a < DEPTH; a += 2) begin
         rd_addr[0] = AW'(a);
         rd_addr[1] = AW'(a + 1);
         #1;
         for (int r = 0; r < NR; r++) begin
            check_val(tag, rd_data[r], 32'd0);
            check_val(tag, rd_busy[r], 32'd0);
         end
         cycle(1);
      end
   endtask

   initial begin
      int n;
      reset   = 1'b1;
      rd_addr = '0;
      idle_inputs();
      @(negedge clock);
      cycle(0);
      cycle(0);
      reset = 1'b0;
      check_val("rst_ready", ready, 32'd1);

      // Writes through each port, then read back.
      wr_en = 2'b01; wr_addr[0] = 4'd0; wr_data[0] = 8'h91;
      cycle(1);
      wr_en = 2'b10; wr_addr[1] = 4'd1; wr_data[1] = 8'h97;
      cycle(1);
      idle_inputs();
      rd_addr[0] = 4'd0; rd_addr[1] = 4'd1;
      #1;
      check_val("tp_w0", rd_data[0], 32'h91);
      check_val("tp_w1", rd_data[1], 32'h97);
      check_val("tp_z0", rd_data_z[0], 32'h00);
      cycle(1);

      // Same-address conflict: highest port wins, visible through bypass.
      wr_en = 2'b11; wr_addr[0] = 4'd3; wr_addr[1] = 4'd3;
      wr_data[0] = 8'hAA; wr_data[1] = 8'h55; rd_addr[0] = 4'd3;
      #1;
      check_val("tp_byp", rd_data[0], 32'h55);
      cycle(1);
      idle_inputs();
      #1;
      check_val("tp_conf", rd_data[0], 32'h55);
      cycle(1);

      // Reservation, write clearing busy, then reservation + write together.
      rsv_en = 1'b1; rsv_addr = 4'd5; rd_addr[0] = 4'd5;
      cycle(1);
      idle_inputs();
      #1;
      check_val("tp_rsv", rd_busy[0], 32'd1);
      cycle(1);
      wr_en = 2'b01; wr_addr[0] = 4'd5; wr_data[0] = 8'h0F;
      cycle(1);
      idle_inputs();
      #1;
      check_val("tp_wclr_b", rd_busy[0], 32'd0);
      check_val("tp_wclr_d", rd_data[0], 32'h0F);
      cycle(1);
      wr_en = 2'b01; wr_addr[0] = 4'd5; wr_data[0] = 8'h0F; rsv_en = 1'b1; rsv_addr = 4'd5;
      cycle(1);
      idle_inputs();
      #1;
      check_val("tp_both_b", rd_busy[0], 32'd1);
      check_val("tp_both_d", rd_data[0], 32'h0F);
      cycle(1);

      // Hardwired zero register ignores writes and reservations.
      wr_en = 2'b10; wr_addr[1] = 4'd0; wr_data[1] = 8'hFF; rsv_en = 1'b1; rsv_addr = 4'd0;
      rd_addr[0] = 4'd0;
      cycle(1);
      idle_inputs();
      #1;
      check_val("tp_zreg_d", rd_data_z[0], 32'h00);
      check_val("tp_zreg_b", rd_busy_z[0], 32'd0);
      check_val("tp_nz_d", rd_data[0], 32'hFF);
      cycle(1);

      // Full clear: ready low for exactly DEPTH cycles, traffic meanwhile dropped.
      fill_all();
      clear = 1'b1;
      cycle(1);
      n = 0;
      while (ready == 1'b0 && n < 40) begin
         wr_en      = NW'($urandom_range(0, 3));
         wr_addr[0] = AW'($urandom_range(0, DEPTH - 1));
         wr_addr[1] = AW'($urandom_range(0, DEPTH - 1));
         wr_data[0] = DW'($urandom_range(1, 255));
         wr_data[1] = DW'($urandom_range(1, 255));
         rsv_en     = 1'($urandom_range(0, 1));
         rsv_addr   = AW'($urandom_range(0, DEPTH - 1));
         clear      = 1'($urandom_range(0, 1));
         rd_addr[0] = AW'($urandom_range(0, DEPTH - 1));
         rd_addr[1] = wr_addr[0];
         cycle(1);
         n++;
      end
      check_val("clr_len", n, DEPTH);
      sweep_zero("clr_zero");

      // Reset in the seventh cycle of a clear.
      fill_all();
      clear = 1'b1;
      cycle(1);
      clear = 1'b0;
      for (int c = 0; c < 6; c++) cycle(1);
      reset = 1'b1;
      cycle(1);
      reset = 1'b0;
      #1;
      check_val("mid_rst_rdy", ready, 32'd1);
      sweep_zero("mid_rst_zero");

      // Random traffic.
      for (int k = 0; k < 400; k++) begin
         for (int r = 0; r < NR; r++) rd_addr[r] = AW'($urandom_range(0, DEPTH - 1));
         for (int i = 0; i < NW; i++) begin
            wr_en[i]   = 1'($urandom_range(0, 1));
            wr_addr[i] = AW'($urandom_range(0, DEPTH - 1));
            wr_data[i] = DW'($urandom);
         end
         if ($urandom_range(0, 3) == 0) wr_addr[1] = wr_addr[0];
         if ($urandom_range(0, 2) == 0) rd_addr[0] = wr_addr[$urandom_range(0, 1)];
         rsv_en   = ($urandom_range(0, 2) == 0);
         rsv_addr = ($urandom_range(0, 2) == 0) ? wr_addr[0] : AW'($urandom_range(0, DEPTH - 1));
         clear    = ($urandom_range(0, 49) == 0);
         reset    = ($urandom_range(0, 149) == 0);
         cycle(1);
      end
      reset = 1'b0;
      idle_inputs();
      cycle(1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
